// File: rtl/sip_bitplane_feeder.sv
// sip_bitplane_feeder
//
// Takes one packed activation vector and one packed weight vector over a
// valid/ready handshake. It then replays them as 1-bit planes, one
// (activation bit a, weight bit w) pair per slice. Weight bit w is the outer
// loop and activation bit a is the inner loop. Each slice is tagged with a
// shift amount (a + w), the sign flags and the first/last markers that the
// downstream shift-accumulator needs.
//
// Ports:
//   i_CLK, i_RST          clock, synchronous active-high reset
//   i_Valid / o_Ready     operand pair handshake
//   i_ActVec, i_WVec      packed lane data (lane k at [BITS*k +: BITS])
//   i_PrecA, i_PrecW      requested precisions (0 -> 1, clamped to BITS_*)
//   i_SignA, i_SignW      two's-complement flags
//   i_Bin                 binary XNOR mode (forces 1x1 unsigned)
//   o_SliceValid / i_SliceReady  slice handshake
//   o_Act, o_Weight       bit-planes, one bit per lane
//   o_SignI, o_NegW       current plane is the signed MSB
//   o_Bin, o_Shift, o_First, o_Last  slice tags
module sip_bitplane_feeder #(
    parameter int N_DOT  = 32,
    parameter int BITS_A = 8,
    parameter int BITS_W = 8
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic                      i_Valid,
    output logic                      o_Ready,
    input  logic [N_DOT*BITS_A-1:0]   i_ActVec,
    input  logic [N_DOT*BITS_W-1:0]   i_WVec,
    input  logic [3:0]                i_PrecA,
    input  logic [3:0]                i_PrecW,
    input  logic                      i_SignA,
    input  logic                      i_SignW,
    input  logic                      i_Bin,
    output logic                      o_SliceValid,
    input  logic                      i_SliceReady,
    output logic [N_DOT-1:0]          o_Act,
    output logic [N_DOT-1:0]          o_Weight,
    output logic                      o_SignI,
    output logic                      o_NegW,
    output logic                      o_Bin,
    output logic [3:0]                o_Shift,
    output logic                      o_First,
    output logic                      o_Last
);

    localparam int AIW = (BITS_A > 1) ? $clog2(BITS_A) : 1;
    localparam int WIW = (BITS_W > 1) ? $clog2(BITS_W) : 1;
    localparam logic [3:0] MAX_A = 4'(BITS_A);
    localparam logic [3:0] MAX_W = 4'(BITS_W);

    typedef enum logic {IDLE, STREAM} state_t;

    // Zero means one bit; anything above the datapath width is clamped.
    function automatic logic [3:0] eff_prec(input logic [3:0] p, input logic [3:0] max_p);
        logic [3:0] r;
        if (p == 4'd0) begin
            r = 4'd1;
        end else if (p > max_p) begin
            r = max_p;
        end else begin
            r = p;
        end
        return r;
    endfunction

    state_t                    state_r, nxt_state_s;
    logic [N_DOT*BITS_A-1:0]   act_r, nxt_act_s;
    logic [N_DOT*BITS_W-1:0]   wv_r, nxt_wv_s;
    logic [3:0]                pa_r, pw_r, nxt_pa_s, nxt_pw_s;
    logic [3:0]                a_r, w_r, nxt_a_s, nxt_w_s;
    logic                      sa_r, sw_r, bin_r, nxt_sa_s, nxt_sw_s, nxt_bin_s;
    logic                      ready_r;

    logic                      valid_r, valid_s;
    logic [N_DOT-1:0]          act_pl_r, act_pl_s, w_pl_r, w_pl_s;
    logic                      sign_i_r, sign_i_s, neg_w_r, neg_w_s, bin_o_r, bin_o_s;
    logic [3:0]                shift_r, shift_s;
    logic                      first_r, first_s, last_r, last_s;
    logic [BITS_A-1:0]         lane_a_s;
    logic [BITS_W-1:0]         lane_w_s;

    // ready_r is the registered IDLE flag; gating with i_RST keeps o_Ready low
    // in every reset cycle while letting it rise right after reset releases.
    assign o_Ready      = ready_r & ~i_RST;
    assign o_SliceValid = valid_r;
    assign o_Act        = act_pl_r;
    assign o_Weight     = w_pl_r;
    assign o_SignI      = sign_i_r;
    assign o_NegW       = neg_w_r;
    assign o_Bin        = bin_o_r;
    assign o_Shift      = shift_r;
    assign o_First      = first_r;
    assign o_Last       = last_r;

    // Next-state: accept a pair in IDLE, walk (a, w) in STREAM.
    always_comb begin
        nxt_state_s = state_r;
        nxt_act_s   = act_r;
        nxt_wv_s    = wv_r;
        nxt_pa_s    = pa_r;
        nxt_pw_s    = pw_r;
        nxt_sa_s    = sa_r;
        nxt_sw_s    = sw_r;
        nxt_bin_s   = bin_r;
        nxt_a_s     = a_r;
        nxt_w_s     = w_r;
        case (state_r)
            IDLE: begin
                if (i_Valid && o_Ready) begin
                    nxt_act_s = i_ActVec;
                    nxt_wv_s  = i_WVec;
                    nxt_bin_s = i_Bin;
                    if (i_Bin) begin
                        nxt_pa_s = 4'd1;
                        nxt_pw_s = 4'd1;
                        nxt_sa_s = 1'b0;
                        nxt_sw_s = 1'b0;
                    end else begin
                        nxt_pa_s = eff_prec(i_PrecA, MAX_A);
                        nxt_pw_s = eff_prec(i_PrecW, MAX_W);
                        nxt_sa_s = i_SignA;
                        nxt_sw_s = i_SignW;
                    end
                    nxt_a_s     = 4'd0;
                    nxt_w_s     = 4'd0;
                    nxt_state_s = STREAM;
                end else begin
                    nxt_state_s = IDLE;
                end
            end
            STREAM: begin
                if (i_SliceReady) begin
                    if (last_r) begin
                        nxt_state_s = IDLE;
                    end else if (a_r == pa_r - 4'd1) begin
                        nxt_a_s = 4'd0;
                        nxt_w_s = w_r + 4'd1;
                    end else begin
                        nxt_a_s = a_r + 4'd1;
                    end
                end else begin
                    nxt_state_s = STREAM;
                end
            end
            default: begin
                nxt_state_s = IDLE;
            end
        endcase
    end

    // Slice contents for the next cycle, so every slice output is a flop.
    always_comb begin
        valid_s  = 1'b0;
        act_pl_s = '0;
        w_pl_s   = '0;
        sign_i_s = 1'b0;
        neg_w_s  = 1'b0;
        bin_o_s  = 1'b0;
        shift_s  = 4'd0;
        first_s  = 1'b0;
        last_s   = 1'b0;
        lane_a_s = '0;
        lane_w_s = '0;
        if (nxt_state_s == STREAM) begin
            valid_s = 1'b1;
            for (int k = 0; k < N_DOT; k++) begin
                lane_a_s    = nxt_act_s[BITS_A*k +: BITS_A];
                lane_w_s    = nxt_wv_s[BITS_W*k +: BITS_W];
                act_pl_s[k] = lane_a_s[nxt_a_s[AIW-1:0]];
                w_pl_s[k]   = lane_w_s[nxt_w_s[WIW-1:0]];
            end
            sign_i_s = nxt_sa_s && (nxt_a_s == nxt_pa_s - 4'd1);
            neg_w_s  = nxt_sw_s && (nxt_w_s == nxt_pw_s - 4'd1);
            bin_o_s  = nxt_bin_s;
            shift_s  = nxt_a_s + nxt_w_s;
            first_s  = (nxt_a_s == 4'd0) && (nxt_w_s == 4'd0);
            last_s   = (nxt_a_s == nxt_pa_s - 4'd1) && (nxt_w_s == nxt_pw_s - 4'd1);
        end else begin
            valid_s = 1'b0;
        end
    end

    // State, latched operands and registered slice outputs.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_r  <= IDLE;
            act_r    <= '0;
            wv_r     <= '0;
            pa_r     <= 4'd1;
            pw_r     <= 4'd1;
            sa_r     <= 1'b0;
            sw_r     <= 1'b0;
            bin_r    <= 1'b0;
            a_r      <= 4'd0;
            w_r      <= 4'd0;
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            act_pl_r <= '0;
            w_pl_r   <= '0;
            sign_i_r <= 1'b0;
            neg_w_r  <= 1'b0;
            bin_o_r  <= 1'b0;
            shift_r  <= 4'd0;
            first_r  <= 1'b0;
            last_r   <= 1'b0;
        end else begin
            state_r  <= nxt_state_s;
            act_r    <= nxt_act_s;
            wv_r     <= nxt_wv_s;
            pa_r     <= nxt_pa_s;
            pw_r     <= nxt_pw_s;
            sa_r     <= nxt_sa_s;
            sw_r     <= nxt_sw_s;
            bin_r    <= nxt_bin_s;
            a_r      <= nxt_a_s;
            w_r      <= nxt_w_s;
            ready_r  <= (nxt_state_s == IDLE);
            valid_r  <= valid_s;
            act_pl_r <= act_pl_s;
            w_pl_r   <= w_pl_s;
            sign_i_r <= sign_i_s;
            neg_w_r  <= neg_w_s;
            bin_o_r  <= bin_o_s;
            shift_r  <= shift_s;
            first_r  <= first_s;
            last_r   <= last_s;
        end
    end

endmodule

// File: tb/tb_sip_bitplane_feeder.sv
// Self-checking bench for sip_bitplane_feeder: table of stream shapes plus
// hand-written stall and mid-stream reset sequences, with a scoreboard queue
// of expected slices filled at accept time and drained on slice handshakes.
module tb_sip_bitplane_feeder;

    localparam int N  = 32;
    localparam int BA = 8;
    localparam int BW = 8;

    logic              clk = 1'b0;
    logic              i_RST, i_Valid, o_Ready;
    logic [N*BA-1:0]   i_ActVec;
    logic [N*BW-1:0]   i_WVec;
    logic [3:0]        i_PrecA, i_PrecW;
    logic              i_SignA, i_SignW, i_Bin;
    logic              o_SliceValid, i_SliceReady;
    logic [N-1:0]      o_Act, o_Weight;
    logic              o_SignI, o_NegW, o_Bin;
    logic [3:0]        o_Shift;
    logic              o_First, o_Last;

    always #5 clk = ~clk;

    sip_bitplane_feeder #(.N_DOT(N), .BITS_A(BA), .BITS_W(BW)) dut (
        .i_CLK(clk), .i_RST(i_RST), .i_Valid(i_Valid), .o_Ready(o_Ready),
        .i_ActVec(i_ActVec), .i_WVec(i_WVec), .i_PrecA(i_PrecA), .i_PrecW(i_PrecW),
        .i_SignA(i_SignA), .i_SignW(i_SignW), .i_Bin(i_Bin),
        .o_SliceValid(o_SliceValid), .i_SliceReady(i_SliceReady),
        .o_Act(o_Act), .o_Weight(o_Weight), .o_SignI(o_SignI), .o_NegW(o_NegW),
        .o_Bin(o_Bin), .o_Shift(o_Shift), .o_First(o_First), .o_Last(o_Last)
    );

    typedef struct packed {
        logic [N-1:0] act;
        logic [N-1:0] wt;
        logic         sign_i;
        logic         neg_w;
        logic         bn;
        logic [3:0]   shift;
        logic         first;
        logic         last;
    } slice_t;

    typedef struct {
        string      name;
        logic [3:0] pa;
        logic [3:0] pw;
        logic       sa;
        logic       sw;
        logic       bn;
        int         exp_n;
        logic [3:0] exp_last_shift;
    } vec_t;

    slice_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: condition not met", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*BA-1:0] rand_vec();
        logic [N*BA-1:0] v;
        for (int i = 0; i < N*BA/32; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    function automatic slice_t observe();
        slice_t s;
        s.act = o_Act; s.wt = o_Weight; s.sign_i = o_SignI; s.neg_w = o_NegW;
        s.bn = o_Bin; s.shift = o_Shift; s.first = o_First; s.last = o_Last;
        return s;
    endfunction

    // Reference slice sequence straight from the operation rules.
    task automatic push_expected(input logic [N*BA-1:0] av, input logic [N*BW-1:0] wv,
                                 input logic [3:0] pa, input logic [3:0] pw,
                                 input logic sa, input logic sw, input logic bn);
        int epa, epw;
        logic esa, esw;
        slice_t s;
        epa = (pa == 4'd0) ? 1 : ((int'(pa) > BA) ? BA : int'(pa));
        epw = (pw == 4'd0) ? 1 : ((int'(pw) > BW) ? BW : int'(pw));
        esa = sa; esw = sw;
        if (bn) begin epa = 1; epw = 1; esa = 1'b0; esw = 1'b0; end
        for (int w = 0; w < epw; w++) begin
            for (int a = 0; a < epa; a++) begin
                for (int k = 0; k < N; k++) begin
                    s.act[k] = av[BA*k + a];
                    s.wt[k]  = wv[BW*k + w];
                end
                s.sign_i = esa && (a == epa - 1);
                s.neg_w  = esw && (w == epw - 1);
                s.bn     = bn;
                s.shift  = 4'(a + w);
                s.first  = (a == 0) && (w == 0);
                s.last   = (a == epa - 1) && (w == epw - 1);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic compare_slice(input slice_t got, input slice_t ex, input int idx);
        check($sformatf("act[%0d]", idx),    got.act,    ex.act);
        check($sformatf("weight[%0d]", idx), got.wt,     ex.wt);
        check($sformatf("signi[%0d]", idx),  got.sign_i, ex.sign_i);
        check($sformatf("negw[%0d]", idx),   got.neg_w,  ex.neg_w);
        check($sformatf("bin[%0d]", idx),    got.bn,     ex.bn);
        check($sformatf("shift[%0d]", idx),  got.shift,  ex.shift);
        check($sformatf("first[%0d]", idx),  got.first,  ex.first);
        check($sformatf("last[%0d]", idx),   got.last,   ex.last);
    endtask

    // Offer one pair, then drain its slices. Optional stall on slice stall_at,
    // optional reset pulse on slice rst_at, optional i_Valid noise mid-stream.
    task automatic run_pair(input logic [N*BA-1:0] av, input logic [N*BW-1:0] wv,
                            input logic [3:0] pa, input logic [3:0] pw,
                            input logic sa, input logic sw, input logic bn,
                            input int stall_at, input int stall_len, input int rst_at,
                            input bit valid_during,
                            output int nseen, output logic [3:0] last_shift);
        int guard;
        int stalled;
        bit done;
        slice_t got, held, ex;
        nseen = 0; last_shift = 4'd0; stalled = 0; done = 1'b0; guard = 0;
        held = '0;
        while (!o_Ready && guard < 20) begin step(); guard++; end
        check("ready_before_accept", o_Ready, 1'b1);
        i_ActVec = av; i_WVec = wv; i_PrecA = pa; i_PrecW = pw;
        i_SignA = sa; i_SignW = sw; i_Bin = bn; i_Valid = 1'b1; i_SliceReady = 1'b1;
        push_expected(av, wv, pa, pw, sa, sw, bn);
        step();
        // Scramble the inputs: the latched copy must be what streams out.
        i_Valid = 1'b0; i_ActVec = rand_vec(); i_WVec = rand_vec();
        i_PrecA = 4'($urandom_range(0, 15)); i_PrecW = 4'($urandom_range(0, 15));
        i_SignA = 1'($urandom()); i_SignW = 1'($urandom()); i_Bin = 1'($urandom());
        check("ready_while_busy", o_Ready, 1'b0);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            check("slice_valid", o_SliceValid, 1'b1);
            if (!o_SliceValid) begin
                done = 1'b1;
            end else begin
                got = observe();
                if (nseen == stall_at && stalled < stall_len) begin
                    if (stalled == 0) held = got;
                    else check("stall_hold", got, held);
                    i_SliceReady = 1'b0;
                    i_Valid = valid_during;
                    stalled++;
                    step();
                end else begin
                    if (nseen == stall_at && stalled > 0) check("stall_hold", got, held);
                    i_SliceReady = 1'b1;
                    if (exp_q.size() == 0) begin
                        fail("extra_slice");
                        done = 1'b1;
                    end else begin
                        ex = exp_q.pop_front();
                        compare_slice(got, ex, nseen);
                    end
                    nseen++;
                    last_shift = got.shift;
                    if (nseen - 1 == rst_at) i_RST = 1'b1;
                    i_Valid = valid_during && !got.last;
                    step();
                    i_Valid = 1'b0;
                    if (i_RST) begin
                        i_RST = 1'b0;
                        #1;
                        check("rst_valid", o_SliceValid, 1'b0);
                        check("rst_act", o_Act, '0);
                        check("rst_weight", o_Weight, '0);
                        check("rst_tags", {o_SignI, o_NegW, o_Bin, o_Shift, o_First, o_Last}, '0);
                        check("rst_ready", o_Ready, 1'b1);
                        exp_q.delete();
                        return;
                    end
                    if (got.last) done = 1'b1;
                end
            end
        end
        if (!done) fail("stream_timeout");
        check("ready_after_last", o_Ready, 1'b1);
        check("valid_after_last", o_SliceValid, 1'b0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [N*BA-1:0] av;
        logic [N*BW-1:0] wv;
        int n;
        logic [3:0] ls;

        tbl[0] = '{"binary",   4'd4, 4'd4,  1'b1, 1'b1, 1'b1, 1,  4'd0};
        tbl[1] = '{"u2x2",     4'd2, 4'd2,  1'b0, 1'b0, 1'b0, 4,  4'd2};
        tbl[2] = '{"s4x3",     4'd4, 4'd3,  1'b1, 1'b1, 1'b0, 12, 4'd5};
        tbl[3] = '{"clamp",    4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 8,  4'd7};
        tbl[4] = '{"s8x8",     4'd8, 4'd8,  1'b1, 1'b0, 1'b0, 64, 4'd14};
        tbl[5] = '{"s1x1",     4'd1, 4'd1,  1'b1, 1'b1, 1'b0, 1,  4'd0};

        i_RST = 1'b1; i_Valid = 1'b0; i_SliceReady = 1'b0;
        i_ActVec = '0; i_WVec = '0; i_PrecA = 4'd0; i_PrecW = 4'd0;
        i_SignA = 1'b0; i_SignW = 1'b0; i_Bin = 1'b0;
        step(); step(); step();
        check("reset_ready", o_Ready, 1'b0);
        check("reset_valid", o_SliceValid, 1'b0);
        check("reset_planes", {o_Act, o_Weight}, '0);
        check("reset_tags", {o_SignI, o_NegW, o_Bin, o_Shift, o_First, o_Last}, '0);
        i_RST = 1'b0;
        step();
        check("ready_after_reset", o_Ready, 1'b1);

        for (int t = 0; t < 6; t++) begin
            av = rand_vec(); wv = rand_vec();
            av[7:0] = 8'h05;
            wv[7:0] = 8'h03;
            run_pair(av, wv, tbl[t].pa, tbl[t].pw, tbl[t].sa, tbl[t].sw, tbl[t].bn,
                     -1, 0, -1, 1'b0, n, ls);
            check({"count_", tbl[t].name}, n, tbl[t].exp_n);
            check({"lastshift_", tbl[t].name}, ls, tbl[t].exp_last_shift);
        end

        // 2x2 stream with a 3-cycle stall on slice 1 and i_Valid noise.
        run_pair(rand_vec(), rand_vec(), 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1, 3, -1, 1'b1, n, ls);
        check("count_stall", n, 4);

        // 4x4 stream reset on slice 2; no further slices may appear.
        run_pair(rand_vec(), rand_vec(), 4'd4, 4'd4, 1'b1, 1'b1, 1'b0, -1, 0, 2, 1'b0, n, ls);
        check("count_before_reset", n, 3);
        for (int i = 0; i < 4; i++) begin
            check("post_reset_valid", o_SliceValid, 1'b0);
            check("post_reset_last", o_Last, 1'b0);
            step();
        end
        run_pair(rand_vec(), rand_vec(), 4'd4, 4'd4, 1'b1, 1'b1, 1'b0, -1, 0, -1, 1'b0, n, ls);
        check("count_after_reset", n, 16);
        check("lastshift_after_reset", ls, 4'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sip_bitplane_feeder.md
# sip_bitplane_feeder

Operand-side producer for the XNOR/bit-serial dot-product lanes. It accepts one packed multi-bit activation vector and one packed multi-bit weight vector over a valid/ready handshake. It then streams them out as 1-bit planes, one (activation bit, weight bit) pair per slice, directly onto the lane inputs (`i_Act`, `i_Weight`, `i_SignI`, `bin`). Each slice carries a shift amount and sign tag so the downstream shift-accumulator can weight the adder-tree result.

## Interface
Parameters:
- `N_DOT`, 32, number of dot-product lanes; equals the lane count of the adder tree.
- `BITS_A`, 8, maximum activation precision per lane.
- `BITS_W`, 8, maximum weight precision per lane.

Ports:
- `i_CLK`, input, 1, single clock; all logic is rising-edge.
- `i_RST`, input, 1, synchronous, active-high reset.
- `i_Valid`, input, 1, an operand vector pair is offered.
- `o_Ready`, output, 1, the feeder can accept a pair.
- `i_ActVec`, input, N_DOT*BITS_A, lane k activation at `[BITS_A*k +: BITS_A]`.
- `i_WVec`, input, N_DOT*BITS_W, lane k weight at `[BITS_W*k +: BITS_W]`.
- `i_PrecA`, input, 4, activation precision in bits.
- `i_PrecW`, input, 4, weight precision in bits.
- `i_SignA`, input, 1, activations are two's complement.
- `i_SignW`, input, 1, weights are two's complement.
- `i_Bin`, input, 1, binary XNOR mode.
- `o_SliceValid`, output, 1, the slice outputs are valid.
- `i_SliceReady`, input, 1, the downstream lanes and accumulator accept the slice.
- `o_Act`, output, N_DOT, activation bit-plane (lane k = bit a of activation k).
- `o_Weight`, output, N_DOT, weight bit-plane (lane k = bit w of weight k).
- `o_SignI`, output, 1, the current activation plane is the signed MSB.
- `o_NegW`, output, 1, the current weight plane is the signed MSB.
- `o_Bin`, output, 1, binary mode tag; drives `bin`.
- `o_Shift`, output, 4, shift amount, equal to a + w.
- `o_First`, output, 1, first slice of the pair.
- `o_Last`, output, 1, last slice of the pair.

## Operation
States:
- **IDLE:** `o_Ready`=1 and `o_SliceValid`=0.
- **STREAM:** `o_Ready`=0 and `o_SliceValid`=1.

Accept:
- A pair is accepted when `i_Valid` && `o_Ready`.
- On accept, latch both vectors, the effective precisions, `i_SignA`, `i_SignW` and `i_Bin`.
- Clear the counters to a=0, w=0 and go to STREAM.

Effective precision:
- A value of 0 is treated as 1.
- A value greater than BITS_A (or BITS_W) is treated as BITS_A (or BITS_W).
- If `i_Bin`=1, both precisions are forced to 1 and both sign flags are forced to 0.

Slice order and tags:
- Weight bit w is the outer loop and activation bit a is the inner loop, both ascending.
- The stream contains PA*PW slices in total.
- `o_Act[k]` = latched act[k][a]; `o_Weight[k]` = latched w[k][w].
- `o_SignI` = SignA && (a==PA-1).
- `o_NegW` = SignW && (w==PW-1).
- `o_Shift` = a + w.
- `o_First` = (a==0 && w==0).
- `o_Last` = (a==PA-1 && w==PW-1).

Advancing:
- The stream advances on `o_SliceValid` && `i_SliceReady`.
- On an advance, a increments; when a==PA-1, a wraps to 0 and w increments.
- An advance on the `o_Last` slice returns the block to IDLE.
- While `i_SliceReady`=0, every slice output holds stable.

Other rules:
- All slice outputs are registered.
- In IDLE, `o_Act`, `o_Weight` and all tags are driven to 0.
- `i_Valid` is ignored outside IDLE.
- Input data need only be stable during the accept cycle.

## Timing
Reset:
- While `i_RST`=1, the block sits in IDLE.
- `o_Ready`=0 during the reset cycle(s) and 1 from the first cycle after reset deasserts.
- All other outputs are 0 during reset.
- Reset asserted mid-stream aborts the stream with no `o_Last` emitted; the latched data is discarded.

Latency and throughput:
- An accept at edge T puts the first slice on the outputs after edge T (valid in cycle T+1).
- With `i_SliceReady` held at 1, a pair occupies PA*PW cycles.
- The next accept is possible in the cycle after the `o_Last` handshake, a 1-cycle bubble per pair.

Simultaneous events:
- A stall on the last slice keeps STREAM and `o_Last`=1 until the handshake.
- `i_Valid` asserted during STREAM has no effect until the block returns to IDLE.

## Test plan
- **Binary mode:** `i_Bin`=1, PrecA=PrecW=4, act lane0=4'b0101 and weight lane0=4'b0011, `i_SliceReady`=1.
  - Required: exactly 1 slice, with `o_Bin`=1, `o_Shift`=0, `o_First`=`o_Last`=1, `o_SignI`=`o_NegW`=0, `o_Act[0]`=1, `o_Weight[0]`=1.
  - `o_Ready` returns to 1 two cycles after the accept.
- **2x2 unsigned:** PrecA=PrecW=2.
  - Required: 4 slices with `o_Shift` sequence 0,1,1,2 and (a,w) order (0,0),(1,0),(0,1),(1,1).
  - `o_First` asserted only on slice 0 and `o_Last` only on slice 3.
  - Each plane equals the corresponding bit column of the lane data.
- **Signed 4x3:** SignA=SignW=1, PrecA=4, PrecW=3.
  - Required: 12 slices.
  - `o_SignI`=1 on the slices with a=3 (slices 3, 7, 11).
  - `o_NegW`=1 on slices 8-11.
  - The last slice has `o_Shift`=5.
- **Stall:** in a 2x2 stream, drop `i_SliceReady` for 3 cycles on slice 1.
  - Required: slice 1 outputs are bit-identical across the stall; the total slice count stays 4.
- **Precision clamp:** PrecA=0 and PrecW=15.
  - Required: treated as 1x8, i.e. 8 slices with `o_Shift` 0..7.
- **Reset mid-stream:** assert `i_RST` for 1 cycle on slice 2 of a 4x4 stream.
  - Required: next cycle has `o_SliceValid`=0, all outputs 0 and `o_Ready`=1; no `o_Last` is ever seen for the aborted pair.
  - A new pair accepted afterwards streams correctly from (0,0).
